// File: rtl/mem_stage.sv
// Memory pipeline stage: in-order store buffer drained in the background,
// store-to-load forwarding, and blocking load misses over a req/ack port.
module mem_stage #(
    parameter int SB_DEPTH = 4,
    parameter int ADDR_W   = 30
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          dec_mre,
    input  logic                          dec_mwe,
    input  logic [ADDR_W-1:0]             daddr,
    input  logic [31:0]                   ex_sdata,
    input  logic [31:0]                   ex_res,
    input  logic [6:0]                    ex_rd,
    output logic                          n_stall,
    output logic [31:0]                   wb_res,
    output logic [31:0]                   wb_memdata,
    output logic                          wb_mre,
    output logic [6:0]                    wb_rd,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_ack,
    input  logic [31:0]                   mem_rdata,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    output logic [1:0]                    dbg_state
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH+1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_LOAD  = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] sb_addr [SB_DEPTH];
    logic [31:0]       sb_data [SB_DEPTH];
    logic [PTR_W-1:0]  head, tail, idx;
    logic              hit, pop, push, sb_full, load_miss;
    logic [31:0]       hit_data;

    assign dbg_state = state;

    // Walk oldest to youngest so the last match (youngest store) wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (CNT_W'(i) < sb_count && sb_addr[idx] == daddr) begin
                hit      = 1'b1;
                hit_data = sb_data[idx];
            end
        end
    end

    assign pop       = (state == S_DRAIN) && mem_ack;
    assign sb_full   = (sb_count == CNT_W'(SB_DEPTH));
    assign push      = dec_mwe && (!sb_full || pop);
    assign load_miss = dec_mre && !dec_mwe && !hit;

    always_comb begin
        if (dec_mwe)
            n_stall = push;
        else if (load_miss)
            n_stall = (state == S_LOAD) && mem_ack;
        else
            n_stall = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= daddr;
            sb_data[tail] <= ex_sdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            head       <= '0;
            tail       <= '0;
            sb_count   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            wb_res     <= '0;
            wb_memdata <= '0;
            wb_mre     <= 1'b0;
            wb_rd      <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            if (push && !pop)
                sb_count <= sb_count + CNT_W'(1);
            else if (pop && !push)
                sb_count <= sb_count - CNT_W'(1);

            // Every request returns to IDLE on ack, so two requests never overlap.
            case (state)
                S_IDLE: begin
                    if (load_miss) begin
                        state    <= S_LOAD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= daddr;
                    end else if (sb_count != '0) begin
                        state     <= S_DRAIN;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= sb_addr[head];
                        mem_wdata <= sb_data[head];
                    end
                end
                S_DRAIN, S_LOAD: begin
                    if (mem_ack) begin
                        state   <= S_IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (n_stall) begin
                wb_rd  <= ex_rd;
                wb_mre <= dec_mre && !dec_mwe;
                if (dec_mre && !dec_mwe)
                    wb_memdata <= hit ? hit_data : mem_rdata;
                else if (!dec_mwe)
                    wb_res <= ex_res;
            end else begin
                wb_rd  <= '0;
                wb_mre <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected memory writes.
module tb_mem_stage;
    localparam int SB_DEPTH = 4;
    localparam int ADDR_W   = 30;
    localparam int CNT_W    = $clog2(SB_DEPTH+1);

    logic              clk = 1'b0;
    logic              rst;
    logic              dec_mre, dec_mwe;
    logic [ADDR_W-1:0] daddr;
    logic [31:0]       ex_sdata, ex_res;
    logic [6:0]        ex_rd;
    logic              n_stall;
    logic [31:0]       wb_res, wb_memdata;
    logic              wb_mre;
    logic [6:0]        wb_rd;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [CNT_W-1:0]  sb_count;
    logic [1:0]        dbg_state;

    logic [ADDR_W+31:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int reads_issued = 0;

    mem_stage #(.SB_DEPTH(SB_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .dec_mre(dec_mre), .dec_mwe(dec_mwe), .daddr(daddr),
        .ex_sdata(ex_sdata), .ex_res(ex_res), .ex_rd(ex_rd), .n_stall(n_stall),
        .wb_res(wb_res), .wb_memdata(wb_memdata), .wb_mre(wb_mre), .wb_rd(wb_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .sb_count(sb_count), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nop();
        dec_mre = 1'b0; dec_mwe = 1'b0; ex_rd = '0; ex_res = '0;
    endtask

    task automatic store(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        dec_mre = 1'b0; dec_mwe = 1'b1; daddr = a; ex_sdata = d; ex_rd = '0;
    endtask

    task automatic load(input logic [ADDR_W-1:0] a, input logic [6:0] rd);
        dec_mre = 1'b1; dec_mwe = 1'b0; daddr = a; ex_rd = rd;
    endtask

    // Wait for a pending drain write, ack it for one cycle.
    task automatic drain_one();
        int n = 0;
        while (!(mem_req && mem_we) && n < 10) begin
            tick();
            n++;
        end
        chk("drain_wait", 64'(mem_req && mem_we), 64'(1));
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
    endtask

    // Write scoreboard plus read-issue counter, sampled mid-cycle.
    always @(negedge clk) begin
        #2;
        if (!rst && mem_req && !mem_we) reads_issued++;
        if (!rst && mem_req && mem_we && mem_ack) begin
            if (exp_q.size() == 0)
                chk("mem_write_unexpected", {2'b0, mem_addr, mem_wdata}, 64'h0);
            else
                chk("mem_write", {2'b0, mem_addr, mem_wdata}, {2'b0, exp_q.pop_front()});
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_ack = 1'b0; mem_rdata = '0; daddr = '0; ex_sdata = '0;
        nop();
        @(negedge clk);
        tick(); tick();
        rst = 1'b0;
        #1;
        // Reset state
        chk("rst_wb_res", 64'(wb_res), 64'(0));
        chk("rst_wb_memdata", 64'(wb_memdata), 64'(0));
        chk("rst_wb_mre", 64'(wb_mre), 64'(0));
        chk("rst_wb_rd", 64'(wb_rd), 64'(0));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_we", 64'(mem_we), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        chk("rst_sb_count", 64'(sb_count), 64'(0));
        chk("rst_n_stall", 64'(n_stall), 64'(1));
        chk("rst_state", 64'(dbg_state), 64'(0));

        // Non-memory op, latency 1
        ex_res = 32'hCAFE0001; ex_rd = 7'h41;
        tick();
        chk("alu_wb_res", 64'(wb_res), 64'hCAFE0001);
        chk("alu_wb_rd", 64'(wb_rd), 64'h41);

        // Store then forwarded load, no read issued
        store(30'h100, 32'hDEADBEEF); exp_q.push_back({30'h100, 32'hDEADBEEF});
        #1 chk("st_n_stall", 64'(n_stall), 64'(1));
        tick();
        load(30'h100, 7'h45);
        #1 chk("fwd_n_stall", 64'(n_stall), 64'(1));
        tick();
        nop();
        chk("fwd_wb_memdata", 64'(wb_memdata), 64'hDEADBEEF);
        chk("fwd_wb_mre", 64'(wb_mre), 64'(1));
        chk("fwd_wb_rd", 64'(wb_rd), 64'h45);
        chk("fwd_no_read", 64'(reads_issued), 64'(0));
        drain_one();
        chk("t2_sb_count", 64'(sb_count), 64'(0));

        // Youngest-match forwarding and in-order drain
        store(30'h10, 32'd1); exp_q.push_back({30'h10, 32'd1});
        tick();
        store(30'h10, 32'd2); exp_q.push_back({30'h10, 32'd2});
        tick();
        load(30'h10, 7'h42);
        tick();
        nop();
        chk("young_wb_memdata", 64'(wb_memdata), 64'(2));
        chk("young_sb_count", 64'(sb_count), 64'(2));
        chk("drain_addr", 64'(mem_addr), 64'h10);
        drain_one();
        drain_one();
        chk("t3_sb_count", 64'(sb_count), 64'(0));
        chk("t3_q_empty", 64'(exp_q.size()), 64'(0));

        // Fill the buffer, fifth store stalls until a pop
        for (int i = 0; i < 4; i++) begin
            store(30'h20 + 30'(i), 32'hA0 + 32'(i)); exp_q.push_back({30'h20 + 30'(i), 32'hA0 + 32'(i)});
            #1 chk("fill_n_stall", 64'(n_stall), 64'(1));
            tick();
        end
        store(30'h24, 32'hA4);
        #1 chk("full_n_stall", 64'(n_stall), 64'(0));
        tick();
        chk("full_sb_count", 64'(sb_count), 64'(4));
        chk("full_bubble_mre", 64'(wb_mre), 64'(0));
        mem_ack = 1'b1;
        #1 chk("pop_n_stall", 64'(n_stall), 64'(1));
        exp_q.push_back({30'h24, 32'hA4});
        tick();
        mem_ack = 1'b0;
        nop();
        chk("pushpop_sb_count", 64'(sb_count), 64'(4));
        for (int i = 0; i < 4; i++) drain_one();
        tick();
        chk("t4_sb_count", 64'(sb_count), 64'(0));
        chk("t4_q_empty", 64'(exp_q.size()), 64'(0));

        // Load miss with 3-cycle memory latency
        load(30'h200, 7'h43);
        #1 chk("miss_n_stall0", 64'(n_stall), 64'(0));
        tick();
        chk("miss_req", {mem_req, mem_we, 2'b0, mem_addr}, {1'b1, 1'b0, 2'b0, 30'h200});
        chk("miss_state", 64'(dbg_state), 64'(2));
        chk("miss_n_stall1", 64'(n_stall), 64'(0));
        tick();
        chk("miss_n_stall2", 64'(n_stall), 64'(0));
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        #1 chk("miss_ack_n_stall", 64'(n_stall), 64'(1));
        tick();
        mem_ack = 1'b0; nop();
        chk("miss_wb_memdata", 64'(wb_memdata), 64'h12345678);
        chk("miss_wb_mre", 64'(wb_mre), 64'(1));
        chk("miss_wb_rd", 64'(wb_rd), 64'h43);
        chk("miss_req_drop", 64'(mem_req), 64'(0));

        // Reset during an outstanding read; late ack ignored
        load(30'h300, 7'h11);
        tick();
        chk("r6_req", 64'(mem_req), 64'(1));
        rst = 1'b1; nop();
        tick();
        rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h55555555;
        #1 chk("r6_req_after_rst", 64'(mem_req), 64'(0));
        tick();
        mem_ack = 1'b0;
        chk("r6_wb_rd", 64'(wb_rd), 64'(0));
        chk("r6_wb_mre", 64'(wb_mre), 64'(0));
        chk("r6_sb_count", 64'(sb_count), 64'(0));
        chk("r6_mem_req", 64'(mem_req), 64'(0));
        chk("r6_state", 64'(dbg_state), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
